// File: rtl/frog_ctrl.sv
// frog_ctrl: turns button presses into tile hops animated on frame ticks, and
// sequences death, respawn, lives, score and game-over for the frog sprite.
module frog_ctrl #(
   parameter int TILE         = 32,
   parameter int X_MIN        = 96,
   parameter int COLS         = 14,
   parameter int ROWS         = 15,
   parameter int START_COL    = 7,
   parameter int START_ROW    = 14,
   parameter int HOP_FRAMES   = 8,
   parameter int DEATH_FRAMES = 64,
   parameter int WIN_FRAMES   = 32,
   parameter int START_LIVES  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       hit,
   output logic [9:0] frog_x,
   output logic [9:0] frog_y,
   output logic [9:0] frog_size,
   output logic       frog_visible,
   output logic [1:0] lives,
   output logic [7:0] score,
   output logic       hop_active,
   output logic       game_over
);

   localparam int CW   = $clog2(COLS);
   localparam int RW   = $clog2(ROWS);
   localparam int HW   = $clog2(HOP_FRAMES) + 1;
   localparam int FMAX = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
   localparam int FW   = $clog2(FMAX) + 1;
   localparam int STEP = TILE / HOP_FRAMES;

   localparam logic [CW-1:0]     COL_LAST   = CW'(COLS - 1);
   localparam logic [RW-1:0]     ROW_LAST   = RW'(ROWS - 1);
   localparam logic [CW-1:0]     COL_START  = CW'(START_COL);
   localparam logic [RW-1:0]     ROW_START  = RW'(START_ROW);
   localparam logic [HW-1:0]     HOP_LAST   = HW'(HOP_FRAMES - 1);
   localparam logic [FW-1:0]     DEATH_LAST = FW'(DEATH_FRAMES - 1);
   localparam logic [FW-1:0]     WIN_LAST   = FW'(WIN_FRAMES - 1);
   localparam logic [1:0]        LIVES_INIT = 2'(START_LIVES);
   localparam logic signed [9:0] STEP_S     = 10'(STEP);

   typedef enum logic [2:0] {S_IDLE, S_HOP, S_DEAD, S_WIN, S_GAME_OVER} state_t;
   typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

   // Score saturates at its all-ones value.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // True when a move in direction d from tile (c,r) stays on the playfield.
   function automatic logic move_ok(input dir_t d, input logic [CW-1:0] c, input logic [RW-1:0] r);
      case (d)
         D_UP:    return (r != '0);
         D_DOWN:  return (r != ROW_LAST);
         D_LEFT:  return (c != '0);
         default: return (c != COL_LAST);
      endcase
   endfunction

   function automatic logic [CW-1:0] tgt_col(input dir_t d, input logic [CW-1:0] c);
      case (d)
         D_LEFT:  return c - CW'(1);
         D_RIGHT: return c + CW'(1);
         default: return c;
      endcase
   endfunction

   function automatic logic [RW-1:0] tgt_row(input dir_t d, input logic [RW-1:0] r);
      case (d)
         D_UP:    return r - RW'(1);
         D_DOWN:  return r + RW'(1);
         default: return r;
      endcase
   endfunction

   state_t               r_state, w_state_nx;
   dir_t                 r_dir, w_dir_nx;
   dir_t                 r_pend_dir, w_pend_dir_nx;
   logic                 r_pend_vld, w_pend_vld_nx;
   logic [CW-1:0]        r_col, w_col_nx;
   logic [RW-1:0]        r_row, w_row_nx;
   logic signed [9:0]    r_off_x, w_off_x_nx;
   logic signed [9:0]    r_off_y, w_off_y_nx;
   logic [HW-1:0]        r_hop_cnt, w_hop_nx;
   logic [FW-1:0]        r_frm_cnt, w_frm_nx;
   logic [1:0]           r_lives, w_lives_nx;
   logic [7:0]           r_score, w_score_nx;
   logic [3:0]           r_btn_prev;

   logic [3:0]           w_btn;
   logic [3:0]           w_press;
   logic                 w_any_press;
   dir_t                 w_press_dir;
   logic [CW-1:0]        w_land_col;
   logic [RW-1:0]        w_land_row;
   logic                 w_next_vld;
   dir_t                 w_next_dir;
   logic signed [9:0]    w_step_x, w_step_y;

   assign w_btn       = {btn_right, btn_left, btn_down, btn_up};
   assign w_press     = w_btn & ~r_btn_prev;
   assign w_any_press = |w_press;
   assign w_land_col  = tgt_col(r_dir, r_col);
   assign w_land_row  = tgt_row(r_dir, r_row);
   assign w_next_vld  = w_any_press | r_pend_vld;
   assign w_next_dir  = w_any_press ? w_press_dir : r_pend_dir;

   // Pick a single press per clk with priority up > down > left > right.
   always_comb begin
      w_press_dir = D_RIGHT;
      if (w_press[0])      w_press_dir = D_UP;
      else if (w_press[1]) w_press_dir = D_DOWN;
      else if (w_press[2]) w_press_dir = D_LEFT;
   end

   // Per-tick pixel step toward the target tile for the current hop direction.
   always_comb begin
      w_step_x = '0;
      w_step_y = '0;
      case (r_dir)
         D_UP:    w_step_y = -STEP_S;
         D_DOWN:  w_step_y = STEP_S;
         D_LEFT:  w_step_x = -STEP_S;
         default: w_step_x = STEP_S;
      endcase
   end

   // Next-state logic: hops, pending move, death, win and restart.
   always_comb begin
      w_state_nx    = r_state;
      w_dir_nx      = r_dir;
      w_pend_vld_nx = r_pend_vld;
      w_pend_dir_nx = r_pend_dir;
      w_col_nx      = r_col;
      w_row_nx      = r_row;
      w_off_x_nx    = r_off_x;
      w_off_y_nx    = r_off_y;
      w_hop_nx      = r_hop_cnt;
      w_frm_nx      = r_frm_cnt;
      w_lives_nx    = r_lives;
      w_score_nx    = r_score;
      case (r_state)
         S_IDLE: begin
            if (hit) begin
               w_state_nx    = S_DEAD;
               w_lives_nx    = r_lives - 2'd1;
               w_pend_vld_nx = 1'b0;
               w_frm_nx      = '0;
            end else if (w_any_press && move_ok(w_press_dir, r_col, r_row)) begin
               w_state_nx = S_HOP;
               w_dir_nx   = w_press_dir;
               w_hop_nx   = '0;
               w_off_x_nx = '0;
               w_off_y_nx = '0;
            end
         end
         S_HOP: begin
            if (hit) begin
               // Offset is left as-is so the frog freezes mid-hop.
               w_state_nx    = S_DEAD;
               w_lives_nx    = r_lives - 2'd1;
               w_pend_vld_nx = 1'b0;
               w_frm_nx      = '0;
            end else begin
               if (w_any_press) begin
                  w_pend_vld_nx = 1'b1;
                  w_pend_dir_nx = w_press_dir;
               end
               if (frame_tick) begin
                  w_hop_nx   = r_hop_cnt + HW'(1);
                  w_off_x_nx = r_off_x + w_step_x;
                  w_off_y_nx = r_off_y + w_step_y;
                  if (r_hop_cnt == HOP_LAST) begin
                     w_col_nx      = w_land_col;
                     w_row_nx      = w_land_row;
                     w_off_x_nx    = '0;
                     w_off_y_nx    = '0;
                     w_hop_nx      = '0;
                     w_pend_vld_nx = 1'b0;
                     if (w_land_row == '0) begin
                        w_state_nx = S_WIN;
                        w_score_nx = sat_inc8(r_score);
                        w_frm_nx   = '0;
                     end else if (w_next_vld && move_ok(w_next_dir, w_land_col, w_land_row)) begin
                        // Pending move chains straight into the next hop.
                        w_dir_nx = w_next_dir;
                     end else begin
                        w_state_nx = S_IDLE;
                     end
                  end
               end
            end
         end
         S_DEAD: begin
            if (frame_tick) begin
               w_frm_nx = r_frm_cnt + FW'(1);
               if (r_frm_cnt == DEATH_LAST) begin
                  if (r_lives == 2'd0) begin
                     w_state_nx = S_GAME_OVER;
                  end else begin
                     w_state_nx = S_IDLE;
                     w_col_nx   = COL_START;
                     w_row_nx   = ROW_START;
                     w_off_x_nx = '0;
                     w_off_y_nx = '0;
                  end
               end
            end
         end
         S_WIN: begin
            if (frame_tick) begin
               w_frm_nx = r_frm_cnt + FW'(1);
               if (r_frm_cnt == WIN_LAST) begin
                  w_state_nx = S_IDLE;
                  w_col_nx   = COL_START;
                  w_row_nx   = ROW_START;
               end
            end
         end
         S_GAME_OVER: begin
            if (w_any_press) begin
               w_state_nx    = S_IDLE;
               w_col_nx      = COL_START;
               w_row_nx      = ROW_START;
               w_off_x_nx    = '0;
               w_off_y_nx    = '0;
               w_hop_nx      = '0;
               w_frm_nx      = '0;
               w_pend_vld_nx = 1'b0;
               w_lives_nx    = LIVES_INIT;
               w_score_nx    = '0;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_dir      <= D_UP;
         r_pend_vld <= 1'b0;
         r_pend_dir <= D_UP;
         r_col      <= COL_START;
         r_row      <= ROW_START;
         r_off_x    <= '0;
         r_off_y    <= '0;
         r_hop_cnt  <= '0;
         r_frm_cnt  <= '0;
         r_lives    <= LIVES_INIT;
         r_score    <= '0;
         r_btn_prev <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_dir      <= w_dir_nx;
         r_pend_vld <= w_pend_vld_nx;
         r_pend_dir <= w_pend_dir_nx;
         r_col      <= w_col_nx;
         r_row      <= w_row_nx;
         r_off_x    <= w_off_x_nx;
         r_off_y    <= w_off_y_nx;
         r_hop_cnt  <= w_hop_nx;
         r_frm_cnt  <= w_frm_nx;
         r_lives    <= w_lives_nx;
         r_score    <= w_score_nx;
         r_btn_prev <= w_btn;
      end
   end

   // Sprite visibility: blinks while dead, hidden at game over.
   always_comb begin
      frog_visible = 1'b1;
      case (r_state)
         S_DEAD:      frog_visible = ~r_frm_cnt[3];
         S_GAME_OVER: frog_visible = 1'b0;
         default:     frog_visible = 1'b1;
      endcase
   end

   assign frog_x     = 10'(X_MIN) + 10'(TILE) * 10'(r_col) + $unsigned(r_off_x);
   assign frog_y     = 10'(TILE) * 10'(r_row) + $unsigned(r_off_y);
   assign frog_size  = 10'(TILE);
   assign lives      = r_lives;
   assign score      = r_score;
   assign hop_active = (r_state == S_HOP);
   assign game_over  = (r_state == S_GAME_OVER);

endmodule
